// File: rtl/uart_seq_sender.sv
// uart_seq_sender: 8N1 UART transmitter cycling a character sequence, with single/burst requests and one-deep queueing
module uart_seq_sender #(
  parameter int         CLK_HZ     = 100_000_000,
  parameter int         BAUD       = 9600,
  parameter logic [7:0] CHAR_FIRST = 8'h30,
  parameter logic [7:0] CHAR_LAST  = 8'h7A,
  parameter int         BURST_LEN  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       burst,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic       drop,
  output logic [7:0] cur_char
);
  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int CW = $clog2(BIT_CYC);
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYC - 1);
  localparam logic [7:0] BL = 8'(BURST_LEN);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    frame_q, frame_d;
  logic [7:0]    char_q, char_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          pburst_q, pburst_d;
  logic          drop_q, drop_d;
  logic          last, fin, new_pend;
  logic [7:0]    cnt_dec;

  // next-state: bit timing, frame sequencing, character advance and request queueing
  always_comb begin
    last     = cyc_q == LAST_CYC;
    fin      = state_q == STOP && last;
    cnt_dec  = cnt_q - 8'd1;
    new_pend = start && state_q != IDLE && !pend_q;
    state_d  = state_q;
    cyc_d    = (state_q == IDLE || last) ? '0 : cyc_q + CW'(1);
    bit_d    = bit_q;
    frame_d  = frame_q;
    char_d   = fin ? (char_q == CHAR_LAST ? CHAR_FIRST : char_q + 8'd1) : char_q;
    cnt_d    = fin ? cnt_dec : cnt_q;
    pend_d   = pend_q | new_pend;
    pburst_d = new_pend ? burst : pburst_q;
    drop_d   = start && state_q != IDLE && pend_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = START;
        cnt_d   = burst ? BL : 8'd1;
        frame_d = char_q;
      end
      START: if (last) begin
        state_d = DATA;
        bit_d   = 3'd0;
      end
      DATA: if (last) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (last) begin
        if (cnt_dec != 8'd0) begin
          state_d = START;
          frame_d = char_d;
        end else if (pend_q || start) begin
          state_d = START;
          frame_d = char_d;
          cnt_d   = (pend_q ? pburst_q : burst) ? BL : 8'd1;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      bit_q    <= 3'd0;
      frame_q  <= 8'd0;
      char_q   <= CHAR_FIRST;
      cnt_q    <= 8'd0;
      pend_q   <= 1'b0;
      pburst_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      char_q   <= char_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      pburst_q <= pburst_d;
      drop_q   <= drop_d;
    end
  end

  assign tx       = state_q == START ? 1'b0 : state_q == DATA ? frame_q[bit_q] : 1'b1;
  assign busy     = state_q != IDLE;
  assign tx_done  = fin;
  assign drop     = drop_q;
  assign cur_char = char_q;
endmodule
